// File: rtl/param_seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock.
// The trial subtraction R - D is formed as R + ~D + 1 with a two-half
// carry-select adder. A valid/ready handshake is used on the operand side
// and on the result side.
module param_seq_divider #(
    parameter int WIDTH = 8,
    parameter int SPLIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // Width of the trial subtractor, its upper half, and the bit counter.
    localparam int W1 = WIDTH + 1;
    localparam int UW = W1 - SPLIT;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // Working registers: q shifts the dividend out while quotient bits
    // shift in; r is the partial remainder; d is the captured divisor.
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;
    logic             dbz;

    logic             div_zero;

    // Trial subtractor signals.
    logic [W1-1:0]    a_sub;
    logic [W1-1:0]    nb_sub;
    logic [SPLIT:0]   lo_sum;
    logic [UW:0]      hi_c0;
    logic [UW:0]      hi_c1;
    logic [UW:0]      hi_sel;
    logic [W1-1:0]    diff;
    logic             no_borrow;
    logic [WIDTH-1:0] r_nx;
    logic [WIDTH-1:0] q_nx;
    logic             unused_diff_msb;

    assign div_zero = (divisor == '0);

    // Shift {R,Q} left by one, then subtract the divisor with a carry-select
    // adder: low SPLIT bits ripple with carry-in 1, the upper bits are
    // precomputed for both carry-ins and picked by the low carry-out.
    always_comb begin
        a_sub     = {r, q[WIDTH-1]};
        nb_sub    = ~{1'b0, d};
        lo_sum    = {1'b0, a_sub[SPLIT-1:0]} + {1'b0, nb_sub[SPLIT-1:0]}
                  + {{SPLIT{1'b0}}, 1'b1};
        hi_c0     = {1'b0, a_sub[W1-1:SPLIT]} + {1'b0, nb_sub[W1-1:SPLIT]};
        hi_c1     = {1'b0, a_sub[W1-1:SPLIT]} + {1'b0, nb_sub[W1-1:SPLIT]}
                  + {{UW{1'b0}}, 1'b1};
        hi_sel    = lo_sum[SPLIT] ? hi_c1 : hi_c0;
        no_borrow = hi_sel[UW];
        diff      = {hi_sel[UW-1:0], lo_sum[SPLIT-1:0]};
        // A set top bit of the shifted remainder always means no borrow, so
        // the kept remainder fits in WIDTH bits either way.
        r_nx      = no_borrow ? diff[WIDTH-1:0] : a_sub[WIDTH-1:0];
        q_nx      = {q[WIDTH-2:0], no_borrow};
    end

    assign unused_diff_msb = diff[WIDTH];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand capture and one restoring iteration per CALC cycle; results
    // stay frozen outside IDLE acceptance and CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            r   <= '0;
            d   <= '0;
            cnt <= '0;
            dbz <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (div_zero) begin
                            q   <= '1;
                            r   <= dividend;
                            dbz <= 1'b1;
                        end else begin
                            q   <= dividend;
                            r   <= '0;
                            d   <= divisor;
                            cnt <= CW'(WIDTH - 1);
                            dbz <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    q   <= q_nx;
                    r   <= r_nx;
                    cnt <= cnt - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient    = q;
    assign remainder   = r;
    assign div_by_zero = dbz;

endmodule
